chipmunk_ddr_serializer: RTL and testbench

CHIPMUNK_DDR_SERIALIZER -- requirements
Module: Chipmunk_DdrSerializer

---
 rtl/chipmunk_ddr_serializer.sv | 95 +++++++++
 tb/tb_chipmunk_ddr_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chipmunk_ddr_serializer.sv
// DDR parallel-to-serial transmitter: one holding register feeding a pair shifter.
// Each word goes out MSB first, two bits per clock cycle (high phase, then low phase).
module chipmunk_ddr_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_data,
  output logic             tx_frame,
  output logic             busy
);

  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(WIDTH / 2 - 1);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("chipmunk_ddr_serializer: WIDTH must be even and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] sh;
  logic             hold_valid;
  logic             active;
  logic [CW-1:0]    cnt;
  logic             pos_q;
  logic             stage_q;
  logic             neg_q;
  logic             load_now;
  logic             accept;

  // The shifter can take hold both when idle and on the last pair of a word,
  // which is what keeps back-to-back words gap-free.
  assign load_now = hold_valid && (!active || cnt == '0);
  assign in_ready = !hold_valid || load_now;
  assign accept   = in_valid && in_ready;
  assign busy     = active || hold_valid;
  assign tx_data  = clock ? pos_q : neg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold       <= in_data;
      hold_valid <= 1'b1;
    end else if (load_now) begin
      hold_valid <= 1'b0;
    end
  end

  // Unused low bits of sh fill with zeros; the sh << 2 on load also covers WIDTH=2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      pos_q    <= IDLE_LEVEL;
      stage_q  <= IDLE_LEVEL;
      tx_frame <= 1'b0;
    end else if (load_now) begin
      pos_q    <= hold[WIDTH-1];
      stage_q  <= hold[WIDTH-2];
      sh       <= hold << 2;
      cnt      <= LAST_PAIR;
      active   <= 1'b1;
      tx_frame <= 1'b1;
    end else if (active && cnt != '0) begin
      pos_q    <= sh[WIDTH-1];
      stage_q  <= sh[WIDTH-2];
      sh       <= sh << 2;
      cnt      <= cnt - CW'(1);
      tx_frame <= 1'b1;
    end else begin
      active   <= 1'b0;
      pos_q    <= IDLE_LEVEL;
      stage_q  <= IDLE_LEVEL;
      tx_frame <= 1'b0;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      neg_q <= IDLE_LEVEL;
    end else begin
      neg_q <= stage_q;
    end
  end

endmodule

// File: tb/tb_chipmunk_ddr_serializer.sv
// Scoreboard bench for chipmunk_ddr_serializer: three instances cover WIDTH=8/IDLE=0,
// WIDTH=2/IDLE=1 streaming, and WIDTH=8/IDLE=1 mid-word reset.
module tb_chipmunk_ddr_serializer;

  logic clock;
  logic reset;
  logic resetC;

  logic       v8, rdy8, tx8, fr8, busy8;
  logic [7:0] d8;
  logic       v2, rdy2, tx2, fr2, busy2;
  logic [1:0] d2;
  logic       vC, rdyC, txC, frC, busyC;
  logic [7:0] dC;

  int vectors;
  int miscompares;

  logic [7:0] q8[$];
  logic [1:0] q2[$];
  logic [7:0] bits8;
  logic [1:0] bits2;
  int n8, run8, maxRun8;
  int n2, run2, maxRun2;

  chipmunk_ddr_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u8 (
    .clock(clock), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .tx_data(tx8), .tx_frame(fr8), .busy(busy8)
  );

  chipmunk_ddr_serializer #(.WIDTH(2), .IDLE_LEVEL(1'b1)) u2 (
    .clock(clock), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .tx_data(tx2), .tx_frame(fr2), .busy(busy2)
  );

  chipmunk_ddr_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) uC (
    .clock(clock), .reset(resetC), .in_valid(vC), .in_ready(rdyC), .in_data(dC),
    .tx_data(txC), .tx_frame(frC), .busy(busyC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Deserializers: sample each half-phase 2 time units after its edge.
  always @(posedge clock) begin
    #2;
    if (reset) begin
      n8 = 0; run8 = 0; n2 = 0; run2 = 0;
    end else begin
      if (fr8) begin
        bits8 = {bits8[6:0], tx8}; n8++; run8++;
        if (run8 > maxRun8) maxRun8 = run8;
      end else begin
        run8 = 0;
        checkOutput("idle8_hi", {31'd0, tx8}, 32'd0);
      end
      if (fr2) begin
        bits2 = {bits2[0], tx2}; n2++; run2++;
        if (run2 > maxRun2) maxRun2 = run2;
      end else begin
        run2 = 0;
        checkOutput("idle2_hi", {31'd0, tx2}, 32'd1);
      end
    end
  end

  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (fr8) begin
        bits8 = {bits8[6:0], tx8}; n8++;
        if (n8 == 8) begin
          n8 = 0;
          checkOutput("sb8_avail", {31'd0, q8.size() > 0}, 32'd1);
          if (q8.size() > 0) checkOutput("sb8_word", {24'd0, bits8}, {24'd0, q8.pop_front()});
        end
      end else begin
        checkOutput("idle8_lo", {31'd0, tx8}, 32'd0);
      end
      if (fr2) begin
        bits2 = {bits2[0], tx2}; n2++;
        if (n2 == 2) begin
          n2 = 0;
          checkOutput("sb2_avail", {31'd0, q2.size() > 0}, 32'd1);
          if (q2.size() > 0) checkOutput("sb2_word", {30'd0, bits2}, {30'd0, q2.pop_front()});
        end
      end else begin
        checkOutput("idle2_lo", {31'd0, tx2}, 32'd1);
      end
    end
  end

  // Holds in_valid high across calls; the caller drops it after the last word.
  task automatic applyStimulus8(input logic [7:0] w, output int waits);
    @(negedge clock); #1;
    v8 = 1'b1; d8 = w; waits = 0;
    while (!rdy8 && waits < 40) begin
      @(negedge clock); #1;
      waits++;
    end
    if (!rdy8) checkOutput("rdy8_timeout", {31'd0, rdy8}, 32'd1);
    else q8.push_back(w);
    @(posedge clock); #1;
  endtask

  task automatic applyStimulus2(input logic [1:0] w, output int waits);
    @(negedge clock); #1;
    v2 = 1'b1; d2 = w; waits = 0;
    while (!rdy2 && waits < 40) begin
      @(negedge clock); #1;
      waits++;
    end
    if (!rdy2) checkOutput("rdy2_timeout", {31'd0, rdy2}, 32'd1);
    else q2.push_back(w);
    @(posedge clock); #1;
  endtask

  task automatic drain8();
    int t = 0;
    while (busy8 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    checkOutput("drain8", {31'd0, busy8}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("sb8_left", q8.size(), 32'd0);
    checkOutput("partial8", n8, 32'd0);
  endtask

  task automatic drain2();
    int t = 0;
    while (busy2 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    checkOutput("drain2", {31'd0, busy2}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("sb2_left", q2.size(), 32'd0);
    checkOutput("partial2", n2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    logic [7:0] stream8 [4];
    int expWait8 [4];
    logic [1:0] stream2 [3];
    vectors = 0; miscompares = 0;
    maxRun8 = 0; maxRun2 = 0; n8 = 0; n2 = 0;
    stream8 = '{8'hFF, 8'h00, 8'h5A, 8'hC3};
    expWait8 = '{0, 0, 3, 3};
    stream2 = '{2'b10, 2'b01, 2'b11};
    reset = 1'b1; resetC = 1'b1;
    v8 = 0; d8 = '0; v2 = 0; d2 = '0; vC = 0; dC = '0;

    // Reset state in both phases
    #2;
    checkOutput("rst_tx8_lo", {31'd0, tx8}, 32'd0);
    checkOutput("rst_tx2_lo", {31'd0, tx2}, 32'd1);
    checkOutput("rst_rdy8", {31'd0, rdy8}, 32'd1);
    checkOutput("rst_busy8", {31'd0, busy8}, 32'd0);
    checkOutput("rst_fr8", {31'd0, fr8}, 32'd0);
    @(posedge clock); #1;
    checkOutput("rst_tx8_hi", {31'd0, tx8}, 32'd0);
    checkOutput("rst_txC_hi", {31'd0, txC}, 32'd1);
    @(negedge clock); #1;
    reset = 1'b0; resetC = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Single word 0xA5 from idle: latency and 4-cycle frame
    maxRun8 = 0;
    applyStimulus8(8'hA5, w);
    v8 = 1'b0;
    checkOutput("a5_wait", w, 32'd0);
    checkOutput("a5_busy", {31'd0, busy8}, 32'd1);
    checkOutput("a5_lat_pre", {31'd0, fr8}, 32'd0);
    @(posedge clock); #1;
    checkOutput("a5_lat_frame", {31'd0, fr8}, 32'd1);
    checkOutput("a5_first_bit", {31'd0, tx8}, 32'd1);
    drain8();
    checkOutput("a5_frame_len", maxRun8, 32'd4);

    // Back-to-back stream with hold full: in_ready pattern and continuous frame
    maxRun8 = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus8(stream8[i], w);
      checkOutput($sformatf("stream8_wait%0d", i), w, expWait8[i]);
    end
    v8 = 1'b0;
    drain8();
    checkOutput("stream8_frame_len", maxRun8, 32'd16);

    // WIDTH=2 streaming, idle level 1
    maxRun2 = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus2(stream2[i], w);
      checkOutput($sformatf("stream2_wait%0d", i), w, 32'd0);
    end
    v2 = 1'b0;
    drain2();
    checkOutput("stream2_frame_len", maxRun2, 32'd3);

    // Mid-word asynchronous reset on 0x3C with idle level 1
    @(negedge clock); #1;
    vC = 1'b1; dC = 8'h3C;
    @(posedge clock); #1;
    vC = 1'b0;
    @(posedge clock); #1;
    checkOutput("c_pair0_frame", {31'd0, frC}, 32'd1);
    checkOutput("c_pair0_hi", {31'd0, txC}, 32'd0);
    @(posedge clock); #1;
    checkOutput("c_pair1_hi", {31'd0, txC}, 32'd1);
    #1;
    resetC = 1'b1;
    #1;
    checkOutput("c_rst_tx", {31'd0, txC}, 32'd1);
    checkOutput("c_rst_frame", {31'd0, frC}, 32'd0);
    checkOutput("c_rst_busy", {31'd0, busyC}, 32'd0);
    checkOutput("c_rst_rdy", {31'd0, rdyC}, 32'd1);
    @(negedge clock); #1;
    checkOutput("c_rst_tx_lo", {31'd0, txC}, 32'd1);
    resetC = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checkOutput("c_post_frame", {31'd0, frC}, 32'd0);
      checkOutput("c_post_busy", {31'd0, busyC}, 32'd0);
      checkOutput("c_post_tx_hi", {31'd0, txC}, 32'd1);
      @(negedge clock); #1;
      checkOutput("c_post_tx_lo", {31'd0, txC}, 32'd1);
    end

    // First accept after release keeps the normal latency
    vC = 1'b1; dC = 8'h81;
    @(posedge clock); #1;
    vC = 1'b0;
    checkOutput("c_new_pre", {31'd0, frC}, 32'd0);
    @(posedge clock); #1;
    checkOutput("c_new_frame", {31'd0, frC}, 32'd1);
    checkOutput("c_new_hi", {31'd0, txC}, 32'd1);
    @(negedge clock); #1;
    checkOutput("c_new_lo", {31'd0, txC}, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("c_new_done", {31'd0, busyC}, 32'd0);
    checkOutput("c_new_idle", {31'd0, txC}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
